// File: rtl/al_spi_reader.sv
// ============================================================================
// Module   : al_spi_reader
// Purpose  : Reads one 16-bit word per EXECUTE from an SPI (mode 0) memory
//            for the auto-load sequencer. Optional checksum: AL_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module al_spi_reader #(
  parameter logic [5:0]  MAX_ADDR   = 6'd33,
  parameter int          CLK_DIV    = 2,
  parameter logic [15:0] BLANK_WORD = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EXECUTE,
  input  logic [5:0]  AL_CNT,
  input  logic        AL_ENA,
  input  logic        CLR_AL_DONE,
  output logic        BUSY,
  output logic        AL_DONE,
  output logic [15:0] DATA,
  output logic [5:0]  WADDR,
  output logic        DATA_VLD,
  output logic        CHK_ERR,
  output logic        SCK,
  output logic        CS_B,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [5:0]       r_bit_cnt;
  logic [39:0]      r_frame;
  logic [15:0]      r_rx;
  logic [5:0]       r_addr;
  logic             r_busy;
  logic             r_al_done;
  logic [15:0]      r_data;
  logic [5:0]       r_waddr;
  logic             r_data_vld;
  logic             r_sck;
  logic             r_cs_b;
  logic             r_mosi;

  logic [39:0]      w_frame_init;
  logic             w_div_end;
  logic             w_complete;
  logic             w_last;
  logic             w_blank;

  // 16-bit byte address = word address * 2
  assign w_frame_init = {8'h03, 9'b0, AL_CNT, 1'b0, 16'h0000};
  assign w_div_end    = (r_div_cnt == C_DIV_LAST);
  assign w_complete   = (r_state == ST_CS_HOLD) && w_div_end;
  assign w_last       = (r_addr == MAX_ADDR);
  assign w_blank      = (r_addr == 6'd0) && (r_rx == BLANK_WORD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= 6'd0;
      r_frame    <= 40'd0;
      r_rx       <= 16'h0000;
      r_addr     <= 6'd0;
      r_busy     <= 1'b0;
      r_al_done  <= 1'b0;
      r_data     <= 16'h0000;
      r_waddr    <= 6'd0;
      r_data_vld <= 1'b0;
      r_sck      <= 1'b0;
      r_cs_b     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_data_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_div_cnt <= '0;
          r_bit_cnt <= 6'd0;
          if (EXECUTE && AL_ENA && !r_busy) begin
            r_addr  <= AL_CNT;
            r_frame <= w_frame_init;
            r_mosi  <= w_frame_init[39];
            r_cs_b  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            r_state   <= ST_SHIFT;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_div_end) begin
            r_div_cnt <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
              r_rx  <= {r_rx[14:0], MISO};
            end else begin
              // falling edge: present the next frame bit
              r_sck   <= 1'b0;
              r_frame <= {r_frame[38:0], 1'b0};
              if (r_bit_cnt == 6'd39) begin
                r_bit_cnt <= 6'd0;
                r_mosi    <= 1'b0;
                r_state   <= ST_CS_HOLD;
              end else begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
                r_mosi    <= r_frame[38];
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        ST_CS_HOLD: begin
          if (w_div_end) begin
            r_div_cnt  <= '0;
            r_cs_b     <= 1'b1;
            r_busy     <= 1'b0;
            r_data_vld <= 1'b1;
            r_data     <= r_rx;
            r_waddr    <= r_addr;
            if (w_blank || w_last)
              r_al_done <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // clear has priority over a coincident set
      if (CLR_AL_DONE)
        r_al_done <= 1'b0;
    end
  end

`ifdef AL_CHECKSUM_EN
  logic [15:0] r_chk_acc;
  logic        r_chk_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_chk_acc <= 16'h0000;
      r_chk_err <= 1'b0;
    end else if (CLR_AL_DONE) begin
      r_chk_acc <= 16'h0000;
      r_chk_err <= 1'b0;
    end else if (w_complete && (r_addr <= MAX_ADDR)) begin
      r_chk_acc <= r_chk_acc ^ r_rx;
      if (w_last)
        r_chk_err <= ((r_chk_acc ^ r_rx) != 16'h0000);
    end
  end

  assign CHK_ERR = r_chk_err;
`else
  assign CHK_ERR = 1'b0;
`endif

  assign BUSY     = r_busy;
  assign AL_DONE  = r_al_done;
  assign DATA     = r_data;
  assign WADDR    = r_waddr;
  assign DATA_VLD = r_data_vld;
  assign SCK      = r_sck;
  assign CS_B     = r_cs_b;
  assign MOSI     = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_al_spi_reader.sv
// ============================================================================
// Module   : tb_al_spi_reader
// Purpose  : Self-checking bench for al_spi_reader with an SPI memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_al_spi_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EXECUTE = 1'b0;
  logic [5:0]  AL_CNT = 6'd0;
  logic        AL_ENA = 1'b1;
  logic        CLR_AL_DONE = 1'b0;
  logic        BUSY;
  logic        AL_DONE;
  logic [15:0] DATA;
  logic [5:0]  WADDR;
  logic        DATA_VLD;
  logic        CHK_ERR;
  logic        SCK;
  logic        CS_B;
  logic        MOSI;
  logic        MISO;

  al_spi_reader dut (
    .CLK(CLK), .RST(RST), .EXECUTE(EXECUTE), .AL_CNT(AL_CNT), .AL_ENA(AL_ENA),
    .CLR_AL_DONE(CLR_AL_DONE), .BUSY(BUSY), .AL_DONE(AL_DONE), .DATA(DATA),
    .WADDR(WADDR), .DATA_VLD(DATA_VLD), .CHK_ERR(CHK_ERR), .SCK(SCK),
    .CS_B(CS_B), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 CLK = ~CLK;

  // SPI memory model (mode 0)
  logic [15:0] mem [0:63];
  logic        blank = 1'b0;
  logic        miso_r = 1'b0;
  int          sl_cnt = 0;
  logic [39:0] sl_cap = '0;
  logic [15:0] sl_word = '0;

  assign MISO = blank ? 1'b1 : miso_r;

  always @(negedge CS_B) begin
    sl_cnt = 0;
    sl_cap = '0;
  end
  always @(posedge SCK) if (!CS_B) begin
    sl_cap = {sl_cap[38:0], MOSI};
    sl_cnt++;
  end
  always @(negedge SCK) if (!CS_B) begin
    if (sl_cnt == 24) begin
      sl_word = mem[sl_cap[6:1]];
      miso_r  = sl_word[15];
    end else if (sl_cnt > 24 && sl_cnt < 40) begin
      miso_r = sl_word[39 - sl_cnt];
    end
  end

  int vld_cnt = 0;
  always @(posedge CLK) if (DATA_VLD) vld_cnt++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_read(input logic [5:0] addr, input int mid, output int bcyc);
    EXECUTE = 1'b1;
    AL_CNT  = addr;
    @(negedge CLK);
    EXECUTE = 1'b0;
    bcyc = 0;
    while (BUSY && bcyc < 1000) begin
      bcyc++;
      if (mid == 1 && bcyc == 30) EXECUTE = 1'b1;
      if (mid == 1 && bcyc == 31) EXECUTE = 1'b0;
      if (mid == 2 && bcyc == 30) AL_ENA = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic pulse_clr();
    CLR_AL_DONE = 1'b1;
    @(negedge CLK);
    CLR_AL_DONE = 1'b0;
  endtask

  task automatic run_sweep(output int early, output int vlds, output int bad_busy,
                           output logic done_end);
    int bc;
    int vstart;
    pulse_clr();
    @(negedge CLK);
    vstart   = vld_cnt;
    early    = 0;
    bad_busy = 0;
    for (int a = 0; a < 34; a++) begin
      do_read(a[5:0], 0, bc);
      if (bc != 164) bad_busy++;
      if (a < 33 && AL_DONE) early++;
    end
    done_end = AL_DONE;
    @(negedge CLK);
    @(negedge CLK);
    vlds = vld_cnt - vstart;
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic        blank;
    logic [15:0] exp_data;
    logic        exp_done;
    logic [23:0] exp_hdr;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   bc;
    int   vbefore;
    int   early, vlds, badb;
    logic done_end;

    mem[0] = 16'h1234;
    for (int i = 1; i < 64; i++) mem[i] = 16'hA500 + 16'(i);
    // XOR(1234, A501..A520) = 1234 ^ 0020
    mem[33] = 16'h1214;

    vecs[0] = '{6'd0,  1'b0, 16'h1234, 1'b0, 24'h030000};
    vecs[1] = '{6'd5,  1'b0, 16'hA505, 1'b0, 24'h03000A};
    vecs[2] = '{6'd40, 1'b0, 16'hA528, 1'b0, 24'h030050};
    vecs[3] = '{6'd3,  1'b1, 16'hFFFF, 1'b0, 24'h030006};
    vecs[4] = '{6'd0,  1'b1, 16'hFFFF, 1'b1, 24'h030000};

    repeat (3) @(negedge CLK);
    check("rst_busy",  {39'd0, BUSY},     40'd0);
    check("rst_done",  {39'd0, AL_DONE},  40'd0);
    check("rst_data",  {24'd0, DATA},     40'd0);
    check("rst_waddr", {34'd0, WADDR},    40'd0);
    check("rst_vld",   {39'd0, DATA_VLD}, 40'd0);
    check("rst_chk",   {39'd0, CHK_ERR},  40'd0);
    check("rst_sck",   {39'd0, SCK},      40'd0);
    check("rst_csb",   {39'd0, CS_B},     40'd1);
    check("rst_mosi",  {39'd0, MOSI},     40'd0);
    RST = 1'b0;
    @(negedge CLK);

    for (int v = 0; v < 5; v++) begin
      blank = vecs[v].blank;
      do_read(vecs[v].addr, 0, bc);
      check("vec_busy_cycles", 40'(bc), 40'd164);
      check("vec_vld",   {39'd0, DATA_VLD},        40'd1);
      check("vec_data",  {24'd0, DATA},            {24'd0, vecs[v].exp_data});
      check("vec_waddr", {34'd0, WADDR},           {34'd0, vecs[v].addr});
      check("vec_done",  {39'd0, AL_DONE},         {39'd0, vecs[v].exp_done});
      check("vec_frame", sl_cap,                   {vecs[v].exp_hdr, 16'h0000});
      check("vec_bits",  40'(sl_cnt),              40'd40);
      @(negedge CLK);
      check("vec_vld_1cyc", {39'd0, DATA_VLD},     40'd0);
      if (vecs[v].exp_done) begin
        pulse_clr();
        check("clr_done", {39'd0, AL_DONE}, 40'd0);
      end
    end

    // clear coinciding with a set event: clear wins
    blank = 1'b1;
    CLR_AL_DONE = 1'b1;
    do_read(6'd0, 0, bc);
    CLR_AL_DONE = 1'b0;
    check("clr_wins", {39'd0, AL_DONE}, 40'd0);
    blank = 1'b0;

    // RST 50 cycles into a read
    EXECUTE = 1'b1;
    AL_CNT  = 6'd9;
    @(negedge CLK);
    EXECUTE = 1'b0;
    repeat (49) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_csb",  {39'd0, CS_B}, 40'd1);
    check("midrst_sck",  {39'd0, SCK},  40'd0);
    check("midrst_busy", {39'd0, BUSY}, 40'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    do_read(6'd9, 0, bc);
    check("postrst_busy_cycles", 40'(bc), 40'd164);
    check("postrst_frame", sl_cap, {24'h030012, 16'h0000});
    check("postrst_bits",  40'(sl_cnt), 40'd40);
    check("postrst_data",  {24'd0, DATA}, {24'd0, 16'hA509});

    // AL_ENA dropping mid-read does not truncate the frame
    do_read(6'd7, 2, bc);
    check("enadrop_busy_cycles", 40'(bc), 40'd164);
    check("enadrop_bits", 40'(sl_cnt), 40'd40);
    check("enadrop_data", {24'd0, DATA}, {24'd0, 16'hA507});

    // EXECUTE while AL_ENA low is ignored
    @(negedge CLK);
    vbefore = vld_cnt;
    EXECUTE = 1'b1;
    @(negedge CLK);
    EXECUTE = 1'b0;
    repeat (10) @(negedge CLK);
    check("ena0_busy", {39'd0, BUSY}, 40'd0);
    check("ena0_csb",  {39'd0, CS_B}, 40'd1);
    check("ena0_vlds", 40'(vld_cnt - vbefore), 40'd0);
    AL_ENA = 1'b1;

    // EXECUTE while BUSY is ignored, not queued
    vbefore = vld_cnt;
    do_read(6'd2, 1, bc);
    check("busyexec_cycles", 40'(bc), 40'd164);
    repeat (20) @(negedge CLK);
    check("busyexec_busy", {39'd0, BUSY}, 40'd0);
    check("busyexec_vlds", 40'(vld_cnt - vbefore), 40'd1);

    // back-to-back sweep 0..33 with a consistent image
    run_sweep(early, vlds, badb, done_end);
    check("sweep_early_done", 40'(early), 40'd0);
    check("sweep_vlds",       40'(vlds),  40'd34);
    check("sweep_busy_bad",   40'(badb),  40'd0);
    check("sweep_done_end",   {39'd0, done_end}, 40'd1);
    check("sweep_last_frame", sl_cap, {24'h030042, 16'h0000});
    check("sweep_chk_ok",     {39'd0, CHK_ERR}, 40'd0);

    // corrupted last word
    mem[33] = 16'h1215;
    run_sweep(early, vlds, badb, done_end);
    check("sweep2_vlds", 40'(vlds), 40'd34);
`ifdef AL_CHECKSUM_EN
    check("sweep2_chk_err", {39'd0, CHK_ERR}, 40'd1);
`else
    check("sweep2_chk_err", {39'd0, CHK_ERR}, 40'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
